// File: rtl/nbit_deserializer.sv
// Serial-in/parallel-out receiver for the nbit_shifter link.
// Captures one bit per shift_ena cycle, LSB first, and presents the rebuilt word with a
// valid/ack handshake plus a sticky overrun flag.
// Optional feature: define PARITY_CHECK_EN to append one even-parity bit to each frame and
// report a mismatch on parity_err. Without it the frame is n bits and parity_err is tied 0.
module nbit_deserializer #(
  parameter int unsigned n = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         shift_ena,
  input  logic         serial_in,
  input  logic         ack,
  output logic [n-1:0] outp,
  output logic         valid,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  localparam int unsigned CntW = $clog2(n + 1);

  typedef enum logic [1:0] {StIdle, StRecv, StPar} state_t;

  state_t          state;
  logic [n-1:0]    sr;
  logic [CntW-1:0] cnt;
  logic [n-1:0]    shifted;
  logic            last_data;

  // New bits enter at the top and walk down, so the first bit ends up in bit 0.
  assign shifted   = {serial_in, sr[n-1:1]};
  assign last_data = (cnt == CntW'(n - 1));

`ifndef PARITY_CHECK_EN
  assign parity_err = 1'b0;
`endif

  // Frame FSM with registered handshake outputs; a completion on the same edge as ack
  // takes precedence because its assignments come later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= StIdle;
      sr      <= '0;
      cnt     <= '0;
      outp    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
        parity_err <= 1'b0;
`endif
      end

      case (state)
        StIdle: begin
          // A bit presented together with start is deliberately not captured.
          if (start) begin
            state <= StRecv;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end

        StRecv: begin
          if (shift_ena) begin
            sr <= shifted;
            if (last_data) begin
              cnt <= '0;
`ifdef PARITY_CHECK_EN
              state <= StPar;
`else
              state   <= StIdle;
              busy    <= 1'b0;
              outp    <= shifted;
              valid   <= 1'b1;
              overrun <= valid & ~ack;
`endif
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
        end

`ifdef PARITY_CHECK_EN
        StPar: begin
          if (shift_ena) begin
            state      <= StIdle;
            busy       <= 1'b0;
            outp       <= sr;
            valid      <= 1'b1;
            overrun    <= valid & ~ack;
            // Even parity: data plus parity bit must hold an even number of ones.
            parity_err <= (^sr) ^ serial_in;
          end
        end
`endif

        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nbit_deserializer.sv
// Self-checking bench for nbit_deserializer (n=8). Expected words come straight from the
// transmitted byte; handshake flags are tracked by a frame-level model.
module tb_nbit_deserializer;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         shift_ena = 1'b0;
  logic         serial_in = 1'b0;
  logic         ack = 1'b0;
  logic [N-1:0] outp;
  logic         valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int total = 0;
  int bad   = 0;

  // Frame-level reference state
  logic [N-1:0] exp_outp = '0;
  logic         exp_valid = 1'b0;
  logic         exp_overrun = 1'b0;
  logic         exp_perr = 1'b0;

  nbit_deserializer #(.n(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .shift_ena  (shift_ena),
    .serial_in  (serial_in),
    .ack        (ack),
    .outp       (outp),
    .valid      (valid),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Compare all outputs against the frame-level model.
  task automatic check_all(input string tag, input logic exp_busy);
    total++;
    if (outp !== exp_outp) begin
      bad++; $display("FAIL %s outp got=%h exp=%h", tag, outp, exp_outp);
    end
    total++;
    if (valid !== exp_valid) begin
      bad++; $display("FAIL %s valid got=%b exp=%b", tag, valid, exp_valid);
    end
    total++;
    if (busy !== exp_busy) begin
      bad++; $display("FAIL %s busy got=%b exp=%b", tag, busy, exp_busy);
    end
    total++;
    if (overrun !== exp_overrun) begin
      bad++; $display("FAIL %s overrun got=%b exp=%b", tag, overrun, exp_overrun);
    end
    total++;
    if (parity_err !== exp_perr) begin
      bad++; $display("FAIL %s parity_err got=%b exp=%b", tag, parity_err, exp_perr);
    end
  endtask

  // Model effect of an ack seen on a non-completing edge.
  task automatic model_ack(input logic a);
    if (a) begin
      exp_valid = 1'b0; exp_overrun = 1'b0; exp_perr = 1'b0;
    end
  endtask

  // Send one frame: optional start+shift collision, random gaps, random start/ack noise
  // inside the frame, optional ack on the completing edge, parity bit when enabled.
  task automatic send_frame(input string tag, input logic [N-1:0] w, input int gap_max,
                            input bit noise, input bit ack_last, input logic pbit,
                            input bit start_shift);
    int nbits;
    logic b;
`ifdef PARITY_CHECK_EN
    nbits = N + 1;
`else
    nbits = N;
`endif
    start = 1'b1; shift_ena = start_shift; serial_in = start_shift; ack = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = (i < N) ? w[i] : pbit;
      for (int g = $urandom_range(0, gap_max); g > 0; g--) begin
        shift_ena = 1'b0;
        serial_in = ($urandom_range(0, 1) == 1);
        start = noise && ($urandom_range(0, 1) == 1);
        ack = noise && ($urandom_range(0, 3) == 0);
        tick();
        model_ack(ack);
        check_all({tag, "_gap"}, 1'b1);
      end
      shift_ena = 1'b1;
      serial_in = b;
      start = noise && ($urandom_range(0, 1) == 1);
      if (i == nbits - 1) ack = ack_last;
      else ack = noise && ($urandom_range(0, 3) == 0);
      tick();
      if (i != nbits - 1) begin
        model_ack(ack);
        check_all({tag, "_bit"}, 1'b1);
      end
    end
    shift_ena = 1'b0; start = 1'b0; ack = 1'b0; serial_in = 1'b0;
    exp_overrun = exp_valid && !ack_last;
    exp_valid   = 1'b1;
    exp_outp    = w;
`ifdef PARITY_CHECK_EN
    exp_perr = (^w) ^ pbit;
`else
    exp_perr = 1'b0;
`endif
    check_all({tag, "_done"}, 1'b0);
  endtask

  task automatic do_ack(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    model_ack(1'b1);
    check_all(tag, 1'b0);
  endtask

  task automatic test_reset();
    #1;
    check_all("reset_hold", 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check_all("reset_release", 1'b0);
    // ack with nothing pending changes nothing
    do_ack("ack_idle");
  endtask

  task automatic test_basic();
    logic [N-1:0] w = 8'hA5;
    send_frame("basic", w, 0, 1'b0, 1'b0, ^w, 1'b0);
    do_ack("basic_ack");
  endtask

  task automatic test_gaps();
    logic [N-1:0] w = 8'h3C;
    send_frame("gaps", w, 1, 1'b0, 1'b0, ^w, 1'b0);
    do_ack("gaps_ack");
  endtask

  task automatic test_overrun();
    logic [N-1:0] a = 8'h01;
    logic [N-1:0] b = 8'hFF;
    send_frame("ovr_first", a, 0, 1'b0, 1'b0, ^a, 1'b0);
    send_frame("ovr_second", b, 0, 1'b0, 1'b0, ^b, 1'b0);
    do_ack("ovr_ack");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a = 8'h96;
    logic [N-1:0] b = 8'h4E;
    send_frame("b2b_first", a, 0, 1'b0, 1'b0, ^a, 1'b0);
    // ack lands on the completing edge of the next word: new word wins, no overrun
    send_frame("b2b_ackcomp", b, 0, 1'b0, 1'b1, ^b, 1'b0);
    do_ack("b2b_ack");
  endtask

  task automatic test_async_reset();
    logic [N-1:0] w = 8'h5A;
    send_frame("pre_rst", 8'hC3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      shift_ena = 1'b1; serial_in = 1'b1; tick();
    end
    shift_ena = 1'b0;
    #3 reset = 1'b0;
    #1;
    exp_outp = '0; exp_valid = 1'b0; exp_overrun = 1'b0; exp_perr = 1'b0;
    check_all("async_rst", 1'b0);
    tick();
    reset = 1'b1;
    tick();
    check_all("after_rst", 1'b0);
    send_frame("post_rst", w, 0, 1'b0, 1'b0, ^w, 1'b0);
    do_ack("post_rst_ack");
  endtask

  task automatic test_start_shift();
    logic [N-1:0] w = 8'h00;
    send_frame("start_shift", w, 0, 1'b0, 1'b0, ^w, 1'b1);
    do_ack("start_shift_ack");
  endtask

`ifdef PARITY_CHECK_EN
  task automatic test_parity();
    logic [N-1:0] w = 8'hA5;
    send_frame("par_ok", w, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_ack("par_ok_ack");
    send_frame("par_bad", w, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_ack("par_bad_ack");
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] w;
    for (int f = 0; f < 30; f++) begin
      w = N'($urandom);
      send_frame("rand", w, 2, 1'b1, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      for (int k = $urandom_range(0, 3); k > 0; k--) begin
        // idle: shift_ena/serial_in must be ignored
        shift_ena = ($urandom_range(0, 1) == 1);
        serial_in = ($urandom_range(0, 1) == 1);
        ack = ($urandom_range(0, 2) == 0);
        tick();
        model_ack(ack);
        check_all("rand_idle", 1'b0);
      end
      shift_ena = 1'b0; ack = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_start_shift();
`ifdef PARITY_CHECK_EN
    test_parity();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
